// File: rtl/sdram_uart_dumper.sv
// Dump phase of the sample logger: reads SDRAM words from address 0 upward and
// streams each one to the UART transmitter as four bytes, MSB first.
module sdram_uart_dumper #(
  parameter logic [22:0] LAST_ADDR     = 23'h7FFFFF,
  parameter bit          STOP_ON_EMPTY = 1'b1,
  parameter int          RD_TIMEOUT    = 1023,
  parameter int          TX_GUARD      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err_timeout,
  output logic [22:0] words_sent,
  input  logic        cmd_ready,
  output logic        cmd_enable,
  output logic        cmd_wr,
  output logic [22:0] cmd_address,
  input  logic [31:0] data_out,
  input  logic        data_out_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_en,
  input  logic        tx_active
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam int GW = (TX_GUARD > 1) ? $clog2(TX_GUARD) : 1;
  localparam logic [TW-1:0] TMO_MAX = TW'(RD_TIMEOUT);
  localparam logic [GW-1:0] GRD_MAX = GW'(TX_GUARD - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT, S_CHECK, S_TXW, S_TXP, S_TXG, S_NEXT, S_FIN
  } state_t;

  state_t          state, state_nx;
  logic [31:0]     word;
  logic [1:0]      idx;
  logic [TW-1:0]   tmo;
  logic [GW-1:0]   gcnt;
  logic [7:0]      tx_q;
  logic [7:0]      cur_byte;

  assign cur_byte = word[{idx, 3'b000} +: 8];
  // Byte is presented combinationally during the strobe, then held in tx_q.
  assign tx_byte  = (state == S_TXP) ? cur_byte : tx_q;
  assign cmd_wr   = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    busy       = 1'b1;
    done       = 1'b0;
    cmd_enable = 1'b0;
    tx_en      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_REQ;
      end
      S_REQ: begin
        cmd_enable = 1'b1;
        if (cmd_ready) state_nx = S_WAIT;
      end
      S_WAIT: begin
        if (data_out_ready)      state_nx = S_CHECK;
        else if (tmo == TMO_MAX) state_nx = S_IDLE;
      end
      S_CHECK: state_nx = (STOP_ON_EMPTY && !word[0]) ? S_FIN : S_TXW;
      S_TXW:   if (!tx_active) state_nx = S_TXP;
      S_TXP: begin
        tx_en    = 1'b1;
        state_nx = S_TXG;
      end
      S_TXG:   if (gcnt == GRD_MAX) state_nx = (idx == 2'd0) ? S_NEXT : S_TXW;
      S_NEXT:  state_nx = (cmd_address == LAST_ADDR) ? S_FIN : S_REQ;
      S_FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_address <= '0;
      words_sent  <= '0;
      err_timeout <= 1'b0;
      word        <= '0;
      idx         <= '0;
      tmo         <= '0;
      gcnt        <= '0;
      tx_q        <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cmd_address <= '0;
          words_sent  <= '0;
          err_timeout <= 1'b0;
        end
        S_REQ:   tmo <= '0;
        S_WAIT: begin
          if (data_out_ready)      word <= data_out;
          else if (tmo == TMO_MAX) err_timeout <= 1'b1;
          else                     tmo <= tmo + 1'b1;
        end
        S_CHECK: idx <= 2'd3;
        S_TXP: begin
          tx_q <= cur_byte;
          gcnt <= '0;
        end
        S_TXG: begin
          if (gcnt == GRD_MAX) begin
            if (idx != 2'd0) idx <= idx - 1'b1;
            else             words_sent <= words_sent + 1'b1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        S_NEXT:  if (cmd_address != LAST_ADDR) cmd_address <= cmd_address + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_uart_dumper.sv
// Bench for sdram_uart_dumper: SDRAM and UART models on the falling edge, with a
// byte scoreboard filled from the memory contents and drained on every tx_en.
module tb_sdram_uart_dumper;
  logic clk = 1'b0, rst = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic cmd_ready = 1'b1, data_out_ready = 1'b0, tx_active = 1'b0;
  logic [31:0] data_out = '0;

  logic        busy_a, done_a, err_a, cmd_en_a, cmd_wr_a, tx_en_a;
  logic [22:0] ws_a, addr_a;
  logic [7:0]  txb_a;
  logic        busy_b, done_b, err_b, cmd_en_b, cmd_wr_b, tx_en_b;
  logic [22:0] ws_b, addr_b;
  logic [7:0]  txb_b;

  always #5 clk = ~clk;

  sdram_uart_dumper #(.LAST_ADDR(23'h7FFFFF), .STOP_ON_EMPTY(1'b1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .err_timeout(err_a), .words_sent(ws_a), .cmd_ready(cmd_ready),
    .cmd_enable(cmd_en_a), .cmd_wr(cmd_wr_a), .cmd_address(addr_a),
    .data_out(data_out), .data_out_ready(data_out_ready), .tx_byte(txb_a),
    .tx_en(tx_en_a), .tx_active(tx_active));

  sdram_uart_dumper #(.LAST_ADDR(23'd3), .STOP_ON_EMPTY(1'b0)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .err_timeout(err_b), .words_sent(ws_b), .cmd_ready(cmd_ready),
    .cmd_enable(cmd_en_b), .cmd_wr(cmd_wr_b), .cmd_address(addr_b),
    .data_out(data_out), .data_out_ready(data_out_ready), .tx_byte(txb_b),
    .tx_en(tx_en_b), .tx_active(tx_active));

  bit          sel = 1'b0;
  logic        m_cmd_en, m_tx_en, m_done;
  logic [22:0] m_addr;
  logic [7:0]  m_txb;
  assign m_cmd_en = sel ? cmd_en_b : cmd_en_a;
  assign m_tx_en  = sel ? tx_en_b  : tx_en_a;
  assign m_done   = sel ? done_b   : done_a;
  assign m_addr   = sel ? addr_b   : addr_a;
  assign m_txb    = sel ? txb_b    : txb_a;

  bit          hold_low = 1'b0, no_resp = 1'b0;
  int          uart_len = 5;
  logic [31:0] mem [8];
  int          pend = -1, act = 0;
  int          acc_cnt = 0, tx_cnt = 0, done_cnt = 0;
  logic [22:0] acc_q [$];
  logic [7:0]  exp_q [$];
  int          checks = 0, fails = 0;

  // SDRAM + UART models and scoreboard drain
  always @(negedge clk) begin
    logic [7:0] e;
    data_out_ready = 1'b0;
    cmd_ready = !hold_low;
    if (rst) begin
      pend = -1; act = 0; tx_active = 1'b0;
    end else begin
      if (m_done) done_cnt++;
      if (m_cmd_en && cmd_ready) begin
        acc_cnt++;
        acc_q.push_back(m_addr);
        if (!no_resp) pend = 2;
      end else if (pend > 0) begin
        pend--;
      end else if (pend == 0) begin
        data_out = mem[m_addr[2:0]];
        data_out_ready = 1'b1;
        pend = -1;
      end
      if (m_tx_en) begin
        checks++;
        if (tx_active !== 1'b0) begin
          fails++; $display("FAIL tx_en_while_active: tx_active=%b required 0", tx_active);
        end
        tx_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL tx_unexpected: got byte %02h, required none", m_txb);
        end else begin
          e = exp_q.pop_front();
          if (m_txb !== e) begin
            fails++; $display("FAIL tx_byte: got %02h required %02h", m_txb, e);
          end
        end
        tx_active = 1'b1;
        act = uart_len;
      end else if (act > 0) begin
        act--;
        if (act == 0) tx_active = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start(input bit which);
    tick();
    if (which) start_b = 1'b1; else start_a = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic clear_run();
    exp_q.delete(); acc_q.delete();
    acc_cnt = 0; tx_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 8; i++) mem[i] = '0;
  endtask

  task automatic wait_done(input int max, input string name);
    int n = 0;
    while (done_cnt == 0 && n < max) begin tick(); n++; end
    tick(); tick();
    checks++;
    if (done_cnt != 1) begin
      fails++; $display("FAIL %s_done: done pulses=%0d required 1", name, done_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({busy_a, done_a, err_a, ws_a, cmd_en_a, cmd_wr_a, addr_a, txb_a, tx_en_a} !== '0) begin
      fails++; $display("FAIL reset_a: outputs nonzero busy=%b en=%b addr=%0h ws=%0h required 0", busy_a, cmd_en_a, addr_a, ws_a);
    end
    checks++;
    if ({busy_b, done_b, err_b, ws_b, cmd_en_b, cmd_wr_b, addr_b, txb_b, tx_en_b} !== '0) begin
      fails++; $display("FAIL reset_b: outputs nonzero busy=%b en=%b addr=%0h ws=%0h required 0", busy_b, cmd_en_b, addr_b, ws_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stop_on_empty();
    clear_run(); sel = 1'b0;
    mem[0] = 32'hA1B2C3D5; mem[1] = 32'h0;
    push_word(32'hA1B2C3D5);
    pulse_start(1'b0);
    checks++;
    if (busy_a !== 1'b1) begin fails++; $display("FAIL busy_after_start: got %b required 1", busy_a); end
    wait_done(3000, "stop_empty");
    checks++;
    if (ws_a !== 23'd1) begin fails++; $display("FAIL stop_empty_words: got %0d required 1", ws_a); end
    checks++;
    if (tx_cnt != 4 || exp_q.size() != 0) begin
      fails++; $display("FAIL stop_empty_bytes: sent %0d left %0d required 4 and 0", tx_cnt, exp_q.size());
    end
    checks++;
    if (acc_cnt != 2 || busy_a !== 1'b0) begin
      fails++; $display("FAIL stop_empty_cmds: cmds %0d busy %b required 2 and 0", acc_cnt, busy_a);
    end
  endtask

  task automatic test_last_addr();
    clear_run(); sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem[i] = 32'(i + 1);
      push_word(32'(i + 1));
    end
    pulse_start(1'b1);
    wait_done(5000, "last_addr");
    checks++;
    if (ws_b !== 23'd4) begin fails++; $display("FAIL last_addr_words: got %0d required 4", ws_b); end
    checks++;
    if (acc_q.size() != 4) begin
      fails++; $display("FAIL last_addr_cmds: got %0d required 4", acc_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (acc_q[i] !== 23'(i)) begin
          fails++; $display("FAIL last_addr_addr: got %0h required %0h", acc_q[i], i);
        end
      end
    end
    checks++;
    if (tx_cnt != 16 || exp_q.size() != 0 || addr_b !== 23'd3) begin
      fails++; $display("FAIL last_addr_bytes: sent %0d addr %0h required 16 and 3", tx_cnt, addr_b);
    end
    sel = 1'b0;
  endtask

  task automatic test_cmd_hold();
    int n = 0, bad = 0;
    clear_run(); sel = 1'b0;
    hold_low = 1'b1;
    pulse_start(1'b0);
    while (m_cmd_en !== 1'b1 && n < 20) begin tick(); n++; end
    for (int i = 0; i < 50; i++) begin
      if (m_cmd_en !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin fails++; $display("FAIL hold_cmd_enable: low for %0d cycles required 0", bad); end
    checks++;
    if (acc_cnt != 0 || tx_cnt != 0) begin
      fails++; $display("FAIL hold_no_accept: cmds %0d tx %0d required 0 and 0", acc_cnt, tx_cnt);
    end
    hold_low = 1'b0;
    wait_done(500, "hold");
    checks++;
    if (acc_cnt != 1 || tx_cnt != 0) begin
      fails++; $display("FAIL hold_one_cmd: cmds %0d tx %0d required 1 and 0", acc_cnt, tx_cnt);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    clear_run(); sel = 1'b0;
    no_resp = 1'b1;
    pulse_start(1'b0);
    while (acc_cnt == 0 && n < 50) begin tick(); n++; end
    repeat (1000) tick();
    checks++;
    if (err_a !== 1'b0 || busy_a !== 1'b1) begin
      fails++; $display("FAIL timeout_early: err %b busy %b required 0 and 1", err_a, busy_a);
    end
    n = 0;
    while (err_a !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (err_a !== 1'b1 || busy_a !== 1'b0 || cmd_en_a !== 1'b0) begin
      fails++; $display("FAIL timeout_flag: err %b busy %b en %b required 1 0 0", err_a, busy_a, cmd_en_a);
    end
    tick(); tick();
    checks++;
    if (done_cnt != 0 || err_a !== 1'b1) begin
      fails++; $display("FAIL timeout_no_done: done %0d err %b required 0 and 1", done_cnt, err_a);
    end
    no_resp = 1'b0;
    pulse_start(1'b0);
    checks++;
    if (err_a !== 1'b0) begin fails++; $display("FAIL timeout_clear: err %b required 0", err_a); end
    wait_done(500, "timeout_restart");
  endtask

  task automatic test_slow_uart();
    clear_run(); sel = 1'b0;
    uart_len = 8680;
    mem[0] = 32'hDEADBEEF;
    push_word(32'hDEADBEEF);
    pulse_start(1'b0);
    wait_done(40000, "slow_uart");
    checks++;
    if (tx_cnt != 4 || exp_q.size() != 0 || ws_a !== 23'd1) begin
      fails++; $display("FAIL slow_uart_bytes: sent %0d left %0d words %0d required 4 0 1", tx_cnt, exp_q.size(), ws_a);
    end
    uart_len = 5;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_run(); sel = 1'b0;
    mem[0] = 32'h89ABCDEF; mem[1] = 32'h01234567;
    push_word(32'h89ABCDEF);
    pulse_start(1'b0);
    while (tx_cnt < 2 && n < 500) begin tick(); n++; end
    @(posedge clk); #1;
    rst = 1'b1; #1;
    checks++;
    if ({busy_a, done_a, err_a, ws_a, cmd_en_a, cmd_wr_a, addr_a, txb_a, tx_en_a} !== '0) begin
      fails++; $display("FAIL reset_mid: outputs nonzero busy=%b addr=%0h tx_byte=%02h required 0", busy_a, addr_a, txb_a);
    end
    tick(); rst = 1'b0; tick();
    clear_run();
    mem[0] = 32'h11223345;
    push_word(32'h11223345);
    pulse_start(1'b0);
    n = 0;
    while (tx_cnt < 1 && n < 500) begin tick(); n++; end
    pulse_start(1'b0);
    wait_done(3000, "reset_mid");
    checks++;
    if (acc_q.size() != 2 || acc_q[0] !== 23'd0 || ws_a !== 23'd1) begin
      fails++; $display("FAIL restart_from_zero: cmds %0d words %0d required 2 and 1", acc_q.size(), ws_a);
    end
    checks++;
    if (tx_cnt != 4 || exp_q.size() != 0) begin
      fails++; $display("FAIL spurious_start: sent %0d left %0d required 4 and 0", tx_cnt, exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = '0;
    test_reset();
    test_stop_on_empty();
    test_last_addr();
    test_cmd_hold();
    test_timeout();
    test_slow_uart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
